// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    SEND = 2'd2
  } arb_state_t;

  localparam logic [3:0] UART_ARB_TAG_HDR = 4'hA;
  localparam int         UART_BYTE_W      = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first asserted request at or above
// ptr, searching upward with wrap.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   gnt_idx,
  output logic             any
);

  logic [IDW:0] w_dist;
  logic [IDW:0] w_best;

  // Winner is the requester with the smallest forward distance from ptr.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    w_dist  = '0;
    w_best  = (IDW+1)'(N_REQ);
    for (int j = 0; j < N_REQ; j++) begin
      if ({1'b0, ptr} > (IDW+1)'(j))
        w_dist = (IDW+1)'(j) + (IDW+1)'(N_REQ) - {1'b0, ptr};
      else
        w_dist = (IDW+1)'(j) - {1'b0, ptr};
      if (req[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        gnt_idx = IDW'(j);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte streams.
// Define UART_ARB_TAG_EN to prefix each grant with a {0xA, grant_id} tag byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int IDW       = $clog2(N_REQ),
  parameter int MAX_BURST = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [IDW-1:0]               grant_id,
  output logic                         busy,
  output logic [UART_BYTE_W-1:0]       uart_din,
  output logic                         uart_wr_en,
  input  logic                         uart_wr_rdy
);

  arb_state_t r_state;
  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] r_rr_ptr;
  logic           r_busy;
  logic [7:0]     r_burst_cnt;

  logic [UART_BYTE_W-1:0] w_req_bytes [N_REQ];
  logic [IDW-1:0]         w_gnt_idx;
  logic                   w_any;
  logic                   w_sel_valid;
  logic                   w_sel_last;
  logic                   w_xfer;
  logic                   w_release;
  logic [7:0]             w_burst_inc;
  logic [IDW-1:0]         w_ptr_next;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign w_req_bytes[gi] = req_data[gi*UART_BYTE_W +: UART_BYTE_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_sel_valid = req_valid[r_grant_id];
  assign w_sel_last  = req_last[r_grant_id];
  assign w_xfer      = (r_state == SEND) && w_sel_valid && uart_wr_rdy;
  assign w_burst_inc = (r_burst_cnt == 8'hFF) ? r_burst_cnt : r_burst_cnt + 8'd1;
  assign w_release   = w_xfer && (w_sel_last || (w_burst_inc == 8'(MAX_BURST)));
  assign w_ptr_next  = (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  assign grant_id = r_grant_id;
  assign busy     = r_busy;

  // Owner's stream is passed straight through; nothing is buffered here.
  always_comb begin
    req_ready  = '0;
    uart_din   = '0;
    uart_wr_en = 1'b0;
    case (r_state)
      TAG: begin
        uart_din   = {UART_ARB_TAG_HDR, 4'(r_grant_id)};
        uart_wr_en = 1'b1;
      end
      SEND: begin
        uart_din              = w_req_bytes[r_grant_id];
        uart_wr_en            = w_sel_valid;
        req_ready[r_grant_id] = uart_wr_rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_id  <= w_gnt_idx;
            r_busy      <= 1'b1;
            r_burst_cnt <= '0;
`ifdef UART_ARB_TAG_EN
            r_state     <= TAG;
`else
            r_state     <= SEND;
`endif
          end
        end
        TAG: begin
          if (uart_wr_rdy)
            r_state <= SEND;
        end
        SEND: begin
          if (w_xfer) begin
            r_burst_cnt <= w_burst_inc;
            if (w_release) begin
              r_state  <= IDLE;
              r_busy   <= 1'b0;
              r_rr_ptr <= w_ptr_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the transmit side of one `uart` instance among `N_REQ` byte-stream requesters. Each requester presents bytes with a valid/ready handshake and marks message ends with `req_last`. The arbiter grants the UART to one requester for a whole message, bounded by a burst limit, then moves to the next. It sits between on-chip clients (debug console, status reporter, loader echo) and the `din`/`wr_en`/`wr_rdy` ports of `uart`.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(N_REQ)`: width of the grant index.
- `MAX_BURST`, 16: maximum bytes per grant before forced release, 1..255.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a byte on `req_data[8i+7:8i]`.
- `req_data`  in  8*N_REQ  packed bytes, requester i at bits `[8i+7:8i]`.
- `req_last`  in  N_REQ  qualifies requester i's byte as the last of its message.
- `req_ready`  out  N_REQ  one-hot or zero; byte i is consumed when `req_valid[i] & req_ready[i]`.
- `grant_id`  out  IDW  index of the current owner; valid while `busy`.
- `busy`  out  1  a grant is held.
- `uart_din`  out  8  byte to the UART.
- `uart_wr_en`  out  1  write strobe to the UART.
- `uart_wr_rdy`  in  1  UART can accept a byte; a byte transfers on any cycle with `uart_wr_en & uart_wr_rdy`.

## Operation
- States: IDLE, TAG (only with macro), SEND.
- IDLE: if any `req_valid`, pick the first asserted index searching upward (with wrap) from `rr_ptr`. Register the result in `grant_id`, set `busy`, clear `burst_cnt`, and go to SEND (or TAG). With no request, stay in IDLE.
- SEND: `uart_din = req_data[grant_id]`, `uart_wr_en = req_valid[grant_id]`, `req_ready[grant_id] = uart_wr_rdy`, all other `req_ready` bits 0. This path is combinational pass-through with no byte buffering.
- On each transfer, `burst_cnt` increments (8-bit, saturating, never wraps).
- Release when a transfer has `req_last[grant_id]=1`, or when a transfer brings `burst_cnt` to `MAX_BURST`.
- On release: go to IDLE, clear `busy`, set `rr_ptr = grant_id+1`, wrapping to 0 when it equals `N_REQ`.
- Owner drops `req_valid` mid-message: grant is held, `uart_wr_en=0`, and the arbiter waits indefinitely. There is no timeout.
- Requests from non-owners are ignored until release. `req_valid` deassertion by a non-owner has no effect.
- Index values ≥ `N_REQ` are never granted.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `busy=0`, `grant_id=0`, `rr_ptr=0`, `burst_cnt=0`, `req_ready=0`, `uart_wr_en=0`, `uart_din=0`.
- Reset mid-transfer abandons the message. The UART may have latched a partial stream; the arbiter does not recover it.
- Arbitration latency: a request seen in IDLE at edge k is granted at edge k+1. The first byte can transfer in the cycle after k+1 (SEND), or after TAG completes.
- Re-arbitration bubble: exactly one IDLE cycle between consecutive grants, even with requests pending.
- Simultaneous requests in IDLE: lowest index at or above `rr_ptr` wins.
- Release and a new request arriving on the same edge: the new request is considered in the following IDLE cycle.
- Back-to-back transfers allowed every cycle while `uart_wr_rdy` stays high.

## Configuration
- `UART_ARB_TAG_EN` defined: on each grant, IDLE→TAG. TAG drives `uart_din = {4'hA, 4'(grant_id)}` and `uart_wr_en=1` with all `req_ready` low. It advances to SEND on the cycle `uart_wr_rdy=1`. The tag byte does not count toward `burst_cnt`.
- `UART_ARB_TAG_EN` undefined: no TAG state; IDLE→SEND directly; the byte stream is untagged.

## Structure
- Shared package `uart_pkg`:
  - `arb_state_t` enum (IDLE, TAG, SEND);
  - `UART_ARB_TAG_HDR = 4'hA`;
  - `UART_BYTE_W = 8`.
- One sub-module, `rr_pick`: combinational round-robin priority pick.
  - Inputs: `req[N_REQ]`, `ptr[IDW]`.
  - Outputs: `gnt_idx[IDW]`, `any`.
- FSM, `burst_cnt` and muxing stay in `uart_tx_arbiter`.

## Test plan
- Single requester 1 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33) to a `uart` model with `wr_rdy` always high:
  - 3 transfers on consecutive cycles, `grant_id=1`;
  - `busy` drops after 0x33;
  - `rr_ptr=2`.
- Requesters 0 and 2 both valid from reset, each sending one-byte messages repeatedly:
  - grants alternate 0, 2, 0, 2;
  - one IDLE cycle between grants.
- Requester 3 holds a 40-byte message, `MAX_BURST=16`, requester 0 also pending:
  - after 16 bytes the grant moves to 0;
  - requester 3 resumes later at byte 17;
  - no byte lost or duplicated.
- `uart_wr_rdy` toggles 1 cycle on / 3 cycles off while requester 1 sends 0xA5, 0x5A:
  - `req_ready[1]` mirrors `wr_rdy`;
  - the UART receives exactly 0xA5, 0x5A.
- `rst_n` pulsed low mid-message:
  - all outputs 0 in the same cycle;
  - after release, lowest pending index wins from `rr_ptr=0`.
- With `UART_ARB_TAG_EN`, requester 2 sends 0x7E (last):
  - the loopback `uart` receiver sees 0xA2 then 0x7E.
